// File: rtl/gs_raw_sample_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gs_raw_sample_packer_pkg
// Purpose  : Shared widths, FSM state encodings and helpers for the GS raw
//            sample packer and its word FIFO.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gs_raw_sample_packer_pkg;

    localparam int c_SAMPLE_W = 16;
    localparam int c_WORD_W   = 32;

    // Default upper half of the per-frame trailer word
    localparam logic [c_SAMPLE_W-1:0] c_TRAILER_TAG = 16'hA5A5;

    // Pack FSM state encodings
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_HALF    = 2'd1;
    localparam logic [1:0] c_TRAILER = 2'd2;

    // Saturating increment for the per-frame sample counter
    function automatic logic [c_SAMPLE_W-1:0] sat_inc(input logic [c_SAMPLE_W-1:0] v);
        return (v == {c_SAMPLE_W{1'b1}}) ? v : v + {{(c_SAMPLE_W-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gs_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : gs_word_fifo
// Purpose  : Synchronous word FIFO, depth 2**DEPTH_LOG2, first-word-fall-
//            through read (oDout always shows the head entry).
// Ports    : iClk   - clock, posedge
//            iReset - asynchronous, active-low reset (empties the FIFO)
//            iPush  - write iDin (ignored when full)
//            iPop   - advance the head (ignored when empty)
//            iDin   - write data
//            oDout  - head entry
//            oFull  - no free slot
//            oEmpty - no stored entry
// Revision : 1.0 - initial release
// ============================================================================
module gs_word_fifo
    import gs_raw_sample_packer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iPush,
    input  logic                iPop,
    input  logic [c_WORD_W-1:0] iDin,
    output logic [c_WORD_W-1:0] oDout,
    output logic                oFull,
    output logic                oEmpty
);

    localparam int c_DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    // One extra pointer bit distinguishes full from empty
    logic [DEPTH_LOG2:0] r_wrPtr;
    logic [DEPTH_LOG2:0] r_rdPtr;
    logic [c_WORD_W-1:0] r_mem [c_DEPTH];
    logic                w_wr;
    logic                w_rd;

    assign oEmpty = (r_wrPtr == r_rdPtr);
    assign oFull  = (r_wrPtr[DEPTH_LOG2] != r_rdPtr[DEPTH_LOG2]) &&
                    (r_wrPtr[DEPTH_LOG2-1:0] == r_rdPtr[DEPTH_LOG2-1:0]);

    // Full is evaluated before the pop of the same cycle, so a pop never
    // makes room for a simultaneous push.
    assign w_wr = iPush && !oFull;
    assign w_rd = iPop && !oEmpty;

    assign oDout = r_mem[r_rdPtr[DEPTH_LOG2-1:0]];

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_wr) r_wrPtr <= r_wrPtr + c_PTR_ONE;
            if (w_rd) r_rdPtr <= r_rdPtr + c_PTR_ONE;
        end
    end

    // Storage needs no reset: pointers alone define validity
    always_ff @(posedge iClk) begin
        if (w_wr) r_mem[r_wrPtr[DEPTH_LOG2-1:0]] <= iDin;
    end

endmodule
`default_nettype wire

// File: rtl/gs_raw_sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : gs_raw_sample_packer
// Purpose  : Packs 16-bit raw samples from the GS state machine into 32-bit
//            words, appends a per-frame trailer, buffers words locally and
//            forwards them to the FPGA->host FIFO. Any lost word or sample
//            sets a sticky overflow flag.
// Ports    : iClk          - clock, posedge
//            iReset        - asynchronous, active-low reset
//            i16RawSignal  - raw sample
//            iRawValid     - sample strobe
//            iFrameLast    - sample is last of its frame
//            o32HostData   - host FIFO din (registered)
//            oHostWrEn     - host FIFO wr_en (registered)
//            iHostFull     - host FIFO almost-full
//            iClearOvf     - clear oOverflow
//            oOverflow     - sticky loss flag
//            o16FrameCount - completed frames since reset (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module gs_raw_sample_packer
    import gs_raw_sample_packer_pkg::*;
#(
    parameter int                    DEPTH_LOG2  = 4,
    parameter logic [c_SAMPLE_W-1:0] TRAILER_TAG = c_TRAILER_TAG
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic [c_SAMPLE_W-1:0] i16RawSignal,
    input  logic                  iRawValid,
    input  logic                  iFrameLast,
    output logic [c_WORD_W-1:0]   o32HostData,
    output logic                  oHostWrEn,
    input  logic                  iHostFull,
    input  logic                  iClearOvf,
    output logic                  oOverflow,
    output logic [c_SAMPLE_W-1:0] o16FrameCount
);

    logic [1:0]            r_state;
    logic [1:0]            w_nextState;
    logic [c_SAMPLE_W-1:0] r_lowHalf;
    logic [c_SAMPLE_W-1:0] r_sampleCount;

    logic                  w_push;
    logic [c_WORD_W-1:0]   w_pushData;
    logic                  w_dropSample;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_lost;
    logic                  w_fifoFull;
    logic                  w_fifoEmpty;
    logic [c_WORD_W-1:0]   w_fifoDout;

    // ------------------------------------------------------------------
    // Pack FSM: decides what (if anything) is pushed this cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState  = r_state;
        w_push       = 1'b0;
        w_pushData   = '0;
        w_dropSample = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (iRawValid) begin
                    if (iFrameLast) begin
                        // Odd-length frame: pad the lone sample
                        w_push      = 1'b1;
                        w_pushData  = {{c_SAMPLE_W{1'b0}}, i16RawSignal};
                        w_nextState = c_TRAILER;
                    end else begin
                        w_nextState = c_HALF;
                    end
                end
            end
            c_HALF: begin
                if (iRawValid) begin
                    w_push      = 1'b1;
                    w_pushData  = {i16RawSignal, r_lowHalf};
                    w_nextState = iFrameLast ? c_TRAILER : c_IDLE;
                end
            end
            c_TRAILER: begin
                w_push       = 1'b1;
                w_pushData   = {TRAILER_TAG, r_sampleCount};
                // Upstream broke the idle-after-last rule: sample is lost
                w_dropSample = iRawValid;
                w_nextState  = c_IDLE;
            end
            default: begin
                w_nextState = c_IDLE;
            end
        endcase
    end

    assign w_accept = iRawValid && ((r_state == c_IDLE) || (r_state == c_HALF));
    assign w_pop    = !w_fifoEmpty && !iHostFull;
    assign w_lost   = (w_push && w_fifoFull) || w_dropSample;

    gs_word_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_wordFifo (
        .iClk   (iClk),
        .iReset (iReset),
        .iPush  (w_push),
        .iPop   (w_pop),
        .iDin   (w_pushData),
        .oDout  (w_fifoDout),
        .oFull  (w_fifoFull),
        .oEmpty (w_fifoEmpty)
    );

    // ------------------------------------------------------------------
    // State, counters, overflow flag and registered host interface
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            r_state       <= c_IDLE;
            r_lowHalf     <= '0;
            r_sampleCount <= '0;
            o16FrameCount <= '0;
            oOverflow     <= 1'b0;
            o32HostData   <= '0;
            oHostWrEn     <= 1'b0;
        end else begin
            r_state <= w_nextState;

            if ((r_state == c_IDLE) && iRawValid && !iFrameLast) begin
                r_lowHalf <= i16RawSignal;
            end

            // Counter is cleared as the trailer goes out, so a sample
            // dropped during TRAILER is never counted.
            if (r_state == c_TRAILER) begin
                r_sampleCount <= '0;
                o16FrameCount <= o16FrameCount + 16'd1;
            end else if (w_accept) begin
                r_sampleCount <= sat_inc(r_sampleCount);
            end

            // New loss takes priority over a clear in the same cycle
            if (w_lost) begin
                oOverflow <= 1'b1;
            end else if (iClearOvf) begin
                oOverflow <= 1'b0;
            end

            if (w_pop) begin
                o32HostData <= w_fifoDout;
                oHostWrEn   <= 1'b1;
            end else begin
                oHostWrEn   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gs_raw_sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gs_raw_sample_packer
// Purpose  : Directed self-checking bench for gs_raw_sample_packer
//            (instantiated with DEPTH_LOG2=2, a 4-word internal buffer).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_gs_raw_sample_packer;

    logic        clk = 1'b0;
    logic        rstN;
    logic [15:0] raw;
    logic        valid;
    logic        last;
    logic        hostFull;
    logic        clrOvf;
    logic [31:0] hostData;
    logic        hostWr;
    logic        ovf;
    logic [15:0] frameCnt;

    int          nTotal = 0;
    int          nBad   = 0;
    logic [31:0] got [$];
    logic [31:0] expQ [$];
    bit          prevFull = 1'b0;

    always #5 clk = ~clk;

    gs_raw_sample_packer #(
        .DEPTH_LOG2  (2),
        .TRAILER_TAG (16'hA5A5)
    ) dut (
        .iClk          (clk),
        .iReset        (rstN),
        .i16RawSignal  (raw),
        .iRawValid     (valid),
        .iFrameLast    (last),
        .o32HostData   (hostData),
        .oHostWrEn     (hostWr),
        .iHostFull     (hostFull),
        .iClearOvf     (clrOvf),
        .oOverflow     (ovf),
        .o16FrameCount (frameCnt)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTotal++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Host-side monitor, sampled on the falling edge. prevFull holds the
    // iHostFull value seen by the preceding rising edge.
    always @(negedge clk) begin
        if (prevFull) checkVal("wr_after_full", {31'b0, hostWr}, 32'h0);
        if (hostWr) got.push_back(hostData);
        prevFull = hostFull;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendSample(input logic [15:0] d, input logic l, input int gap);
        valid = 1'b1;
        raw   = d;
        last  = l;
        tick(1);
        valid = 1'b0;
        last  = 1'b0;
        tick(gap);
    endtask

    task automatic checkWords(input string tag);
        logic [31:0] obs;
        checkVal({tag, "_count"}, got.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            obs = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
            checkVal($sformatf("%s_w%0d", tag, i), obs, expQ[i]);
        end
        got.delete();
        expQ.delete();
    endtask

    task automatic scenario1(input string tag);
        for (int k = 1; k <= 4; k++) sendSample(16'(k), (k == 4), 1);
        tick(10);
        expQ.push_back(32'h00020001);
        expQ.push_back(32'h00040003);
        expQ.push_back(32'hA5A50004);
        checkWords(tag);
    endtask

    initial begin
        logic [15:0] lo;
        logic [15:0] hi;
        rstN = 1'b0; raw = '0; valid = 1'b0; last = 1'b0;
        hostFull = 1'b0; clrOvf = 1'b0;
        tick(3);

        // Reset state
        checkVal("rst_data",  hostData, 32'h0);
        checkVal("rst_wren",  {31'b0, hostWr}, 32'h0);
        checkVal("rst_ovf",   {31'b0, ovf}, 32'h0);
        checkVal("rst_frame", {16'b0, frameCnt}, 32'h0);
        rstN = 1'b1;
        tick(2);

        // 1: even frame of four samples
        scenario1("s1");
        checkVal("s1_frame", {16'b0, frameCnt}, 32'd1);

        // 2: odd frame, last sample padded
        sendSample(16'h1111, 1'b0, 1);
        sendSample(16'h2222, 1'b0, 1);
        sendSample(16'h3333, 1'b1, 1);
        tick(10);
        expQ.push_back(32'h22221111);
        expQ.push_back(32'h00003333);
        expQ.push_back(32'hA5A50003);
        checkWords("s2");
        checkVal("s2_frame", {16'b0, frameCnt}, 32'd2);

        // 3: host stalled, 4-word buffer overflows on the 5th push
        hostFull = 1'b1;
        tick(1);
        for (int k = 1; k <= 12; k++) begin
            sendSample(16'h3000 + 16'(k), 1'b0, 1);
            if (k == 8)  checkVal("s3_ovf_4th", {31'b0, ovf}, 32'h0);
            if (k == 10) checkVal("s3_ovf_5th", {31'b0, ovf}, 32'h1);
        end
        checkVal("s3_stalled", got.size(), 32'd0);
        hostFull = 1'b0;
        tick(10);
        expQ.push_back(32'h30023001);
        expQ.push_back(32'h30043003);
        expQ.push_back(32'h30063005);
        expQ.push_back(32'h30083007);
        checkWords("s3");
        checkVal("s3_ovf_sticky", {31'b0, ovf}, 32'h1);
        clrOvf = 1'b1;
        tick(1);
        clrOvf = 1'b0;
        checkVal("s3_ovf_clr", {31'b0, ovf}, 32'h0);
        sendSample(16'h300D, 1'b1, 1);
        tick(8);
        expQ.push_back(32'h0000300D);
        expQ.push_back(32'hA5A5000D);
        checkWords("s3_tail");
        checkVal("s3_frame", {16'b0, frameCnt}, 32'd3);

        // 5: sample arriving in the trailer cycle is dropped
        sendSample(16'h5001, 1'b0, 0);
        sendSample(16'h5002, 1'b1, 0);
        sendSample(16'h5003, 1'b0, 1);
        checkVal("s5_ovf", {31'b0, ovf}, 32'h1);
        tick(8);
        expQ.push_back(32'h50025001);
        expQ.push_back(32'hA5A50002);
        checkWords("s5");
        clrOvf = 1'b1;
        tick(1);
        clrOvf = 1'b0;
        checkVal("s5_ovf_clr", {31'b0, ovf}, 32'h0);
        sendSample(16'h5004, 1'b1, 1);
        tick(8);
        expQ.push_back(32'h00005004);
        expQ.push_back(32'hA5A50001);
        checkWords("s5_next");
        checkVal("s5_frame", {16'b0, frameCnt}, 32'd5);

        // 6: host full toggling every cycle over a 20-sample frame
        for (int c = 0; c < 40; c++) begin
            hostFull = ~hostFull;
            if (c % 2 == 0) begin
                valid = 1'b1;
                raw   = 16'h6000 + 16'(c / 2 + 1);
                last  = (c == 38);
            end else begin
                valid = 1'b0;
                last  = 1'b0;
            end
            tick(1);
        end
        valid = 1'b0;
        last  = 1'b0;
        for (int c = 0; c < 30; c++) begin
            hostFull = ~hostFull;
            tick(1);
        end
        hostFull = 1'b0;
        tick(5);
        for (int i = 0; i < 10; i++) begin
            lo = 16'h6000 + 16'(2 * i + 1);
            hi = 16'h6000 + 16'(2 * i + 2);
            expQ.push_back({hi, lo});
        end
        expQ.push_back(32'hA5A50014);
        checkWords("s6");
        checkVal("s6_ovf", {31'b0, ovf}, 32'h0);
        checkVal("s6_frame", {16'b0, frameCnt}, 32'd6);

        // 4: reset mid-frame, then a clean frame must match scenario 1
        sendSample(16'h7777, 1'b0, 1);
        rstN = 1'b0;
        tick(2);
        checkVal("s4_rst_frame", {16'b0, frameCnt}, 32'h0);
        checkVal("s4_rst_wren", {31'b0, hostWr}, 32'h0);
        rstN = 1'b1;
        tick(2);
        got.delete();
        scenario1("s4");
        checkVal("s4_frame", {16'b0, frameCnt}, 32'd1);
        checkVal("s4_ovf", {31'b0, ovf}, 32'h0);

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
`default_nettype wire
